mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-stage controller that sits directly upstream of the M/W pipeline register.
- Takes the EX/MEM-latched access (aluFinalM as address, wrtDataM as store data) and drives a multi-cycle, handshaked data memory.
- Holds the pipeline while the memory is busy and delivers memOutM, plus a qualified valid bit, to the M/W register.
- Detects misaligned accesses, memory-reported errors and timeouts.

Parameters:
- TIMEOUT, 20: max cycles waited in BUSY for memDone before declaring an error.
- CNT_W, 5: wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- validM  in  1  stage holds a real instruction (not a bubble).
- memReadM  in  1  instruction is a load.
- memWriteM  in  1  instruction is a store.
- aluFinalM  in  16  byte address.
- wrtDataM  in  16  store data.
- memAddr  out  16  address to data memory.
- memDataIn  out  16  write data to data memory.
- memRd  out  1  read request (one-cycle pulse).
- memWr  out  1  write request (one-cycle pulse).
- memDataOut  in  16  read data from memory, valid with memDone.
- memDone  in  1  access complete (may be the request cycle = hit).
- memErr  in  1  memory-side error, sampled in any cycle memDone could be.
- memOutM  out  16  load result to M/W register.
- stallM  out  1  freeze PC, F/D, D/X, X/M; M/W must load a bubble.
- doneM  out  1  stage result valid this cycle (gates regWrt into M/W).
- errM  out  1  one-cycle error pulse (misalign, memErr, timeout).

Behaviour:
- Synchronous, active-high reset. After reset: state IDLE, counter 0, read-hold register 0, memRd=memWr=0, stallM=0, doneM=0, errM=0, memOutM=0.
- memAddr = aluFinalM and memDataIn = wrtDataM at all times (combinational).
- Access = validM & (memReadM | memWriteM). memReadM & memWriteM both high is treated as an error: no request, errM=1.
- IDLE, no access: doneM=validM, stallM=0, no request.
- IDLE, access, aluFinalM[0]=1: no request, errM=1, doneM=0, stallM=0, stay IDLE.
- IDLE, aligned access: pulse memRd or memWr for exactly this cycle.
  - memDone the same cycle: doneM=1, stallM=0, stay IDLE.
  - memErr the same cycle: errM=1, doneM=0.
  - Otherwise: stallM=1, go to BUSY, counter cleared to 0.
- BUSY: memRd=memWr=0 (the request is never reissued); stallM=1 unless leaving this cycle; counter increments each cycle.
  - memDone: stallM=0, doneM=1, go to IDLE.
  - memErr: errM=1, stallM=0, doneM=0, go to IDLE.
  - counter==TIMEOUT-1 without memDone: errM=1, stallM=0, doneM=0, go to IDLE.
  - memDone and memErr together: error wins.
- memOutM = memDataOut in any cycle with memDone & read; otherwise the read-hold register, which captures memDataOut on each completing read.
- Stores never modify the read-hold register.
- Upstream inputs are frozen by stallM, so the inputs are stable throughout BUSY.
- Reset mid-BUSY: return to IDLE at once, no request replay, stallM deasserts the next cycle.
- Timing: load hit latency is 0 extra cycles. A miss resolving N cycles after the request stalls for N cycles.

Decomposition:
- Shared package: state encoding (IDLE=0, BUSY=1), error-cause constants, default TIMEOUT.
- One sub-module, mem_wait_counter: CNT_W-bit counter with synchronous clear and enable, plus a terminal-count output at TIMEOUT-1.
- State and hold registers use the codebase dff cells.

Test Plan:
- Load hit: addr 0x0010, memDone in the request cycle, data 0xBEEF → memRd pulses 1 cycle, stallM never 1, doneM=1, memOutM=0xBEEF.
- Store miss: addr 0x0020, data 0x1234, memDone 3 cycles after request → memWr high only in cycle 0, stallM=1 for exactly 3 cycles, doneM=1 in cycle 3, memOutM keeps its previous value.
- Misaligned load at 0x0011 → no memRd, errM=1 for one cycle, doneM=0, stallM=0.
- Timeout: load issued, memDone never arrives, TIMEOUT=20 → stallM high for cycles 0..19, errM pulses in cycle 20 with stallM=0, FSM returns to IDLE and the next load hit completes normally.
- Reset at cycle 2 of a pending miss → the next cycle has stallM=0, memRd=0, memOutM=0, and memRd is not re-pulsed.
- Bubble and non-memory ALU op: validM=0 → doneM=0. validM=1 with no mem flags → doneM=1, no request, stallM=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-stage controller.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_MISALIGN = 3'd1,
    ERR_CONFLICT = 3'd2,
    ERR_MEM      = 3'd3,
    ERR_TIMEOUT  = 3'd4
  } err_cause_e;

  localparam int DEF_TIMEOUT = 20;
  localparam int DEF_CNT_W   = 5;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter for the BUSY state; tc flags the last allowed wait cycle.
module mem_wait_counter
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-stage controller: issues one handshaked access per instruction,
// stalls the pipeline while the memory is busy and flags misalign/error/timeout.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validM,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [15:0] aluFinalM,
  input  logic [15:0] wrtDataM,
  output logic [15:0] memAddr,
  output logic [15:0] memDataIn,
  output logic        memRd,
  output logic        memWr,
  input  logic [15:0] memDataOut,
  input  logic        memDone,
  input  logic        memErr,
  output logic [15:0] memOutM,
  output logic        stallM,
  output logic        doneM,
  output logic        errM
);

  state_e      state, next_state;
  err_cause_e  cause;
  logic [15:0] rd_hold;
  logic        rd_done;
  logic        access;
  logic        timeout_tc;

  assign memAddr   = aluFinalM;
  assign memDataIn = wrtDataM;
  assign access    = validM & (memReadM | memWriteM);

  mem_wait_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .en  (state == BUSY),
    .tc  (timeout_tc)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    cause      = ERR_NONE;
    memRd      = 1'b0;
    memWr      = 1'b0;
    stallM     = 1'b0;
    doneM      = 1'b0;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (!access) begin
          doneM = validM;
        end else if (memReadM && memWriteM) begin
          cause = ERR_CONFLICT;
        end else if (aluFinalM[0]) begin
          cause = ERR_MISALIGN;
        end else begin
          memRd = memReadM;
          memWr = memWriteM;
          if (memErr) begin
            cause = ERR_MEM;
          end else if (memDone) begin
            doneM   = 1'b1;
            rd_done = memReadM;
          end else begin
            stallM     = 1'b1;
            next_state = BUSY;
          end
        end
      end
      BUSY: begin
        // Inputs are frozen by stallM, so memReadM still describes the pending access.
        next_state = IDLE;
        if (memErr) begin
          cause = ERR_MEM;
        end else if (memDone) begin
          doneM   = 1'b1;
          rd_done = memReadM;
        end else if (timeout_tc) begin
          cause = ERR_TIMEOUT;
        end else begin
          stallM     = 1'b1;
          next_state = BUSY;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign errM    = (cause != ERR_NONE);
  assign memOutM = rd_done ? memDataOut : rd_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_hold <= '0;
    end else begin
      state <= next_state;
      if (rd_done) rd_hold <= memDataOut;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random transactions
// compared against a transaction-level model of the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        validM, memReadM, memWriteM;
  logic [15:0] aluFinalM, wrtDataM;
  logic [15:0] memAddr, memDataIn;
  logic        memRd, memWr;
  logic [15:0] memDataOut;
  logic        memDone, memErr;
  logic [15:0] memOutM;
  logic        stallM, doneM, errM;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_hold;

  localparam int TMO = 20;

  mem_stage #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .validM     (validM),
    .memReadM   (memReadM),
    .memWriteM  (memWriteM),
    .aluFinalM  (aluFinalM),
    .wrtDataM   (wrtDataM),
    .memAddr    (memAddr),
    .memDataIn  (memDataIn),
    .memRd      (memRd),
    .memWr      (memWr),
    .memDataOut (memDataOut),
    .memDone    (memDone),
    .memErr     (memErr),
    .memOutM    (memOutM),
    .stallM     (stallM),
    .doneM      (doneM),
    .errM       (errM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are already driven; sample at the falling edge, then advance one cycle.
  task automatic expect_cycle(input string tag, input logic erd, input logic ewr,
                              input logic estall, input logic edone, input logic eerr,
                              input logic [15:0] eout);
    @(negedge clk);
    check({tag, ".memRd"},     memRd,     erd);
    check({tag, ".memWr"},     memWr,     ewr);
    check({tag, ".stallM"},    stallM,    estall);
    check({tag, ".doneM"},     doneM,     edone);
    check({tag, ".errM"},      errM,      eerr);
    check({tag, ".memOutM"},   memOutM,   eout);
    check({tag, ".memAddr"},   memAddr,   aluFinalM);
    check({tag, ".memDataIn"}, memDataIn, wrtDataM);
    tick();
  endtask

  // One instruction through the stage. lat / err_at are the cycle offsets (from the
  // request cycle) at which the memory raises memDone / memErr; -1 means never.
  task automatic run_txn(input string tag, input logic v, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int lat, input int err_at, input logic [15:0] rdata);
    bit access, bad, ok;
    int fin;
    access = v && (rd || wr);
    bad    = access && ((rd && wr) || addr[0]);
    validM = v; memReadM = rd; memWriteM = wr; aluFinalM = addr; wrtDataM = wdata;
    if (!access || bad) begin
      memDone = 1'b0; memErr = 1'b0; memDataOut = 16'($urandom);
      expect_cycle({tag, ".c0"}, 1'b0, 1'b0, 1'b0, !access && v, bad, exp_hold);
      return;
    end
    fin = TMO; ok = 1'b0;
    if (lat >= 0 && lat <= fin) begin fin = lat; ok = 1'b1; end
    if (err_at >= 0 && err_at <= fin) begin fin = err_at; ok = 1'b0; end
    for (int c = 0; c <= fin; c++) begin
      memDone    = (c == lat);
      memErr     = (c == err_at);
      memDataOut = (c == lat) ? rdata : 16'($urandom);
      expect_cycle($sformatf("%s.c%0d", tag, c), rd && c == 0, wr && c == 0,
                   c < fin, c == fin && ok, c == fin && !ok,
                   (c == fin && ok && rd) ? rdata : exp_hold);
    end
    if (ok && rd) exp_hold = rdata;
    memDone = 1'b0; memErr = 1'b0;
  endtask

  initial begin
    logic v, rd, wr;
    logic [15:0] addr;
    int lat, err_at, r;

    rst = 1'b1; validM = 1'b0; memReadM = 1'b0; memWriteM = 1'b0;
    aluFinalM = '0; wrtDataM = '0; memDataOut = '0; memDone = 1'b0; memErr = 1'b0;
    exp_hold = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    expect_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    run_txn("load_hit",  1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, -1, 16'hBEEF);
    run_txn("store_miss", 1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 3, -1, 16'h5A5A);
    run_txn("misalign",  1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000, 0, -1, 16'h1111);
    run_txn("conflict",  1'b1, 1'b1, 1'b1, 16'h0030, 16'h0000, 0, -1, 16'h2222);
    run_txn("timeout",   1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, -1, -1, 16'h3333);
    run_txn("after_tmo", 1'b1, 1'b1, 1'b0, 16'h0042, 16'h0000, 0, -1, 16'hC0DE);
    run_txn("done_at_tmo", 1'b1, 1'b1, 1'b0, 16'h0044, 16'h0000, TMO, -1, 16'h4444);
    run_txn("err_hit",   1'b1, 1'b1, 1'b0, 16'h0046, 16'h0000, 0, 0, 16'h5555);
    run_txn("err_busy",  1'b1, 1'b0, 1'b1, 16'h0048, 16'h6666, 4, 2, 16'h7777);
    run_txn("err_done",  1'b1, 1'b1, 1'b0, 16'h004A, 16'h0000, 2, 2, 16'h8888);
    run_txn("bubble",    1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000, 0, -1, 16'h9999);
    run_txn("alu_op",    1'b1, 1'b0, 1'b0, 16'h0052, 16'h0000, 0, -1, 16'hAAAA);

    // Reset while a miss is pending; the flushed pipeline presents a bubble afterwards.
    validM = 1'b1; memReadM = 1'b1; memWriteM = 1'b0; aluFinalM = 16'h0060;
    memDone = 1'b0; memErr = 1'b0;
    expect_cycle("rst_miss.c0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, exp_hold);
    expect_cycle("rst_miss.c1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exp_hold);
    rst = 1'b1;
    tick();
    rst = 1'b0; validM = 1'b0; exp_hold = '0;
    expect_cycle("rst_miss.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    expect_cycle("rst_miss.c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    for (int i = 0; i < 150; i++) begin
      v = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 5))
        0:       {rd, wr} = 2'b00;
        1, 2:    {rd, wr} = 2'b10;
        3, 4:    {rd, wr} = 2'b01;
        default: {rd, wr} = 2'b11;
      endcase
      addr = 16'($urandom);
      if ($urandom_range(0, 4) != 0) addr[0] = 1'b0;
      r = $urandom_range(0, 9);
      if (r < 6)      lat = $urandom_range(0, 5);
      else if (r < 8) lat = $urandom_range(6, 21);
      else            lat = -1;
      err_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : -1;
      run_txn($sformatf("rnd%0d", i), v, rd, wr, addr, 16'($urandom), lat, err_at,
              16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
